ir_refresh_ctrl: RTL and testbench
==================================

IR_REFRESH_CTRL -- requirements
Module: ir_refresh_ctrl

Interface
REQ-001 SHALL have ports, clock and reset first: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have reset  in  1  asynchronous, active-low; asserted (0) forces reset state immediately.
REQ-003 SHALL have m1_start  in  1  one-cycle request to begin an opcode-fetch M1 cycle.
REQ-004 SHALL have ld_i_a, ld_r_a  in  1 each  execute LD I,A / LD R,A this cycle.
REQ-005 SHALL have a_in  in  8  accumulator value for LD I,A / LD R,A.
REQ-006 SHALL have im2_ack  in  1, vec_in  in  8  mode-2 interrupt acknowledge strobe and vector byte from the data bus.
REQ-007 SHALL have reg_i, reg_r  in  8 each  current I/R from the IR register file.
REQ-008 SHALL have i_wr, r_wr  out  1 each, i_in, r_in  out  8 each  write controls to the IR register file, combinational from state and inputs.
REQ-009 SHALL have rfsh  out  1, rfsh_addr  out  16  refresh-phase indicator and refresh address.
REQ-010 SHALL have im2_valid  out  1, im2_addr  out  16  mode-2 vector-table address strobe.
REQ-011 SHALL have m1_busy  out  1, m1_overrun  out  1  M1 sequence in progress; one-cycle pulse for a dropped m1_start.

Function
REQ-012 SHALL sequence M1 with states IDLE, T1, T2, T3, T4; each non-IDLE state lasts exactly one clk.
REQ-013 SHALL move IDLE->T1 on m1_start; T1->T2->T3->T4 unconditionally; T4->T1 if m1_start, else T4->IDLE.
REQ-014 SHALL pulse m1_overrun for one cycle and ignore m1_start when it arrives in T1, T2 or T3.
REQ-015 SHALL drive m1_busy=1 in T1..T4, 0 in IDLE.
REQ-016 SHALL drive rfsh=1 and rfsh_addr={reg_i, reg_r} in T3 and T4; rfsh=0 and rfsh_addr=16'h0000 otherwise.
REQ-017 SHALL in T4 assert r_wr with r_in={reg_r[7], reg_r[6:0]+1} (7-bit wrap 7F->00, bit 7 preserved), so R advances at the T4 closing edge.
REQ-018 SHALL on ld_r_a assert r_wr with r_in=a_in in the same cycle, in any state; if coincident with T4, ld_r_a wins and that increment is lost.
REQ-019 SHALL on ld_i_a assert i_wr with i_in=a_in in the same cycle, in any state; i_wr=0 and i_in=0 otherwise.
REQ-020 SHALL drive r_wr=0 and r_in=0 when neither REQ-017 nor REQ-018 applies.
REQ-021 SHALL on im2_ack latch vec_in and pulse im2_valid in the next cycle with im2_addr={reg_i, vec[7:1], 1'b0}; im2_addr holds its last value otherwise.
REQ-022 SHALL, when ld_i_a and im2_ack coincide, form im2_addr from the pre-write I (reg_i sampled in the im2_valid cycle is the new I; the I value at the ack cycle SHALL be latched with the vector).
REQ-023 SHALL allow back-to-back im2_ack; each produces its own im2_valid one cycle later.

Reset
REQ-024 SHALL while reset=0 hold state IDLE and drive every output 0, im2_addr=16'h0000, latched vector/I=0.
REQ-025 SHALL on reset assertion mid-M1 abort the sequence with no pending R increment; first M1 after release starts from IDLE.

Structure
REQ-026 SHALL take its state enum (ir_m1_state_t) and the 7-bit refresh mask constant from the shared z80 package.
REQ-027 SHALL contain no sub-module; it is instantiated beside ir_registers, whose reset the top level drives with the inverse of reset.

Verification
REQ-028 SHALL cover: R=8'h05, m1_start once -> rfsh=1 in T3,T4 with addr {I,05}, R=06 after T4, IDLE next.
REQ-029 SHALL cover: R=8'hFF, one M1 -> R=8'h80; R=8'h7F, one M1 -> R=8'h00.
REQ-030 SHALL cover: m1_start at T4 of each of 3 M1s -> 12 contiguous busy cycles, R+3; m1_start in T2 -> m1_overrun pulse, no extra M1.
REQ-031 SHALL cover: ld_r_a with A=8'h3C in T4 (R=10) -> R=3C, not 11; ld_i_a A=8'h12 -> I=12 next edge.
REQ-032 SHALL cover: I=8'h40, im2_ack vec_in=8'hA7 -> next cycle im2_valid=1, im2_addr=16'h40A6; with ld_i_a A=55 same cycle -> still 40A6.
REQ-033 SHALL cover: reset=0 during T3 -> outputs 0 immediately, R unchanged, IDLE after release.

Source files
------------

// File: rtl/z80_pkg.sv
// ----------------------------------------------------------------------------
// z80_pkg
// Shared Z80 definitions used by the I/R refresh controller.
//   ir_m1_state_t   : opcode-fetch (M1) machine-cycle states
//   R_REFRESH_MASK  : mask for the 7 counting bits of the refresh register R
//   r_refresh_next  : next R value after one M1 (bit 7 kept, bits 6:0 wrap)
// ----------------------------------------------------------------------------
package z80_pkg;

    typedef enum logic [2:0] {
        M1_IDLE = 3'd0,
        M1_T1   = 3'd1,
        M1_T2   = 3'd2,
        M1_T3   = 3'd3,
        M1_T4   = 3'd4
    } ir_m1_state_t;

    // Only R[6:0] counts; R[7] is software-owned and survives the increment.
    localparam logic [6:0] R_REFRESH_MASK = 7'h7F;

    function automatic logic [7:0] r_refresh_next(input logic [7:0] r);
        logic [6:0] low;
        low = (r[6:0] + 7'd1) & R_REFRESH_MASK;
        return {r[7], low};
    endfunction

endpackage : z80_pkg

// File: rtl/ir_refresh_ctrl.sv
// ----------------------------------------------------------------------------
// ir_refresh_ctrl
// Sequences the Z80 opcode-fetch (M1) cycle and produces the write controls
// for the external I/R register file: refresh address and R increment during
// T3/T4, LD I,A / LD R,A writes, and the interrupt mode-2 vector-table address.
//
// Ports
//   clk        in   1   sole clock, rising edge
//   reset      in   1   asynchronous, active-low
//   m1_start   in   1   one-cycle request to begin an M1 cycle
//   ld_i_a     in   1   execute LD I,A this cycle
//   ld_r_a     in   1   execute LD R,A this cycle
//   a_in       in   8   accumulator value for LD I,A / LD R,A
//   im2_ack    in   1   mode-2 interrupt acknowledge strobe
//   vec_in     in   8   vector byte from the data bus
//   reg_i      in   8   current I from the register file
//   reg_r      in   8   current R from the register file
//   i_wr       out  1   write strobe for I     (combinational)
//   i_in       out  8   write data for I       (combinational)
//   r_wr       out  1   write strobe for R     (combinational)
//   r_in       out  8   write data for R       (combinational)
//   rfsh       out  1   refresh phase (T3, T4)
//   rfsh_addr  out 16   refresh address {I, R} during refresh, else 0
//   im2_valid  out  1   one-cycle strobe, cycle after im2_ack
//   im2_addr   out 16   mode-2 vector-table address, holds between strobes
//   m1_busy    out  1   M1 sequence in progress (T1..T4)
//   m1_overrun out  1   pulse: m1_start arrived in T1..T3 and was dropped
// ----------------------------------------------------------------------------
module ir_refresh_ctrl
    import z80_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        m1_start,
    input  logic        ld_i_a,
    input  logic        ld_r_a,
    input  logic [7:0]  a_in,
    input  logic        im2_ack,
    input  logic [7:0]  vec_in,
    input  logic [7:0]  reg_i,
    input  logic [7:0]  reg_r,
    output logic        i_wr,
    output logic [7:0]  i_in,
    output logic        r_wr,
    output logic [7:0]  r_in,
    output logic        rfsh,
    output logic [15:0] rfsh_addr,
    output logic        im2_valid,
    output logic [15:0] im2_addr,
    output logic        m1_busy,
    output logic        m1_overrun
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    ir_m1_state_t state_q, state_d;

    logic       im2_valid_q;
    logic [6:0] vec_q;      // vector bits 7:1; bit 0 is forced to 0 in the address
    logic [7:0] i_lat_q;    // I as it was in the acknowledge cycle

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process evaluation order.
    // Every register here has an async reset; there is no memory array, so
    // nothing is left uninitialised.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= M1_IDLE;
            im2_valid_q <= 1'b0;
            vec_q       <= 7'h00;
            i_lat_q     <= 8'h00;
        end else begin
            state_q     <= state_d;
            im2_valid_q <= im2_ack;
            // Latching I together with the vector means an LD I,A in the
            // acknowledge cycle cannot leak into this interrupt's address.
            if (im2_ack) begin
                vec_q   <= vec_in[7:1];
                i_lat_q <= reg_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    logic in_refresh;
    logic early_phase;

    // NOTE: every output of this block is given a default first, so no
    // path through the case statement can infer a latch.
    always_comb begin
        state_d     = state_q;
        in_refresh  = 1'b0;
        early_phase = 1'b0;
        m1_busy     = 1'b0;

        unique case (state_q)
            M1_IDLE: begin
                if (m1_start) state_d = M1_T1;
            end
            M1_T1: begin
                state_d     = M1_T2;
                m1_busy     = 1'b1;
                early_phase = 1'b1;
            end
            M1_T2: begin
                state_d     = M1_T3;
                m1_busy     = 1'b1;
                early_phase = 1'b1;
            end
            M1_T3: begin
                state_d     = M1_T4;
                m1_busy     = 1'b1;
                early_phase = 1'b1;
                in_refresh  = 1'b1;
            end
            M1_T4: begin
                state_d    = m1_start ? M1_T1 : M1_IDLE;
                m1_busy    = 1'b1;
                in_refresh = 1'b1;
            end
            default: begin
                state_d = M1_IDLE;
            end
        endcase
    end

    // Refresh address is only meaningful while refreshing; zero otherwise so
    // downstream bus muxing can simply OR it in.
    always_comb begin
        rfsh      = in_refresh;
        rfsh_addr = in_refresh ? {reg_i, reg_r} : 16'h0000;
    end

    // A start request that lands mid-fetch is dropped; only T4 may chain.
    always_comb begin
        m1_overrun = reset & m1_start & early_phase;
    end

    // ------------------------------------------------------------------
    // Register-file write controls
    // ------------------------------------------------------------------
    // The write strobes are gated by reset so that nothing is written into
    // I/R while the controller itself is held in reset.
    always_comb begin
        i_wr = 1'b0;
        i_in = 8'h00;
        r_wr = 1'b0;
        r_in = 8'h00;

        if (reset) begin
            if (ld_i_a) begin
                i_wr = 1'b1;
                i_in = a_in;
            end

            // LD R,A overrides the T4 increment; the increment is lost.
            if (ld_r_a) begin
                r_wr = 1'b1;
                r_in = a_in;
            end else if (state_q == M1_T4) begin
                r_wr = 1'b1;
                r_in = r_refresh_next(reg_r);
            end
        end
    end

    // ------------------------------------------------------------------
    // Mode-2 interrupt address
    // ------------------------------------------------------------------
    always_comb begin
        im2_valid = im2_valid_q;
        im2_addr  = {i_lat_q, vec_q, 1'b0};
    end

endmodule : ir_refresh_ctrl

// File: tb/tb_ir_refresh_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ir_refresh_ctrl
// Self-checking bench for ir_refresh_ctrl. A small behavioural I/R register
// file sits beside the DUT and applies its write strobes. Expected refresh
// cycles and mode-2 addresses are queued when stimulus is driven and popped
// when the DUT shows them (m1_busy / im2_valid).
// ----------------------------------------------------------------------------
module tb_ir_refresh_ctrl;

    logic        clk;
    logic        reset;
    logic        m1_start;
    logic        ld_i_a;
    logic        ld_r_a;
    logic [7:0]  a_in;
    logic        im2_ack;
    logic [7:0]  vec_in;
    logic [7:0]  reg_i;
    logic [7:0]  reg_r;
    logic        i_wr;
    logic [7:0]  i_in;
    logic        r_wr;
    logic [7:0]  r_in;
    logic        rfsh;
    logic [15:0] rfsh_addr;
    logic        im2_valid;
    logic [15:0] im2_addr;
    logic        m1_busy;
    logic        m1_overrun;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic        rfsh;
        logic [15:0] addr;
    } rfsh_exp_t;

    rfsh_exp_t   rf_q[$];
    logic [15:0] im2_q[$];

    // Bench-side preset port into the register-file model.
    logic       set_en;
    logic [7:0] set_i;
    logic [7:0] set_r;

    ir_refresh_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .m1_start   (m1_start),
        .ld_i_a     (ld_i_a),
        .ld_r_a     (ld_r_a),
        .a_in       (a_in),
        .im2_ack    (im2_ack),
        .vec_in     (vec_in),
        .reg_i      (reg_i),
        .reg_r      (reg_r),
        .i_wr       (i_wr),
        .i_in       (i_in),
        .r_wr       (r_wr),
        .r_in       (r_in),
        .rfsh       (rfsh),
        .rfsh_addr  (rfsh_addr),
        .im2_valid  (im2_valid),
        .im2_addr   (im2_addr),
        .m1_busy    (m1_busy),
        .m1_overrun (m1_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // I/R register file model; it keeps its contents across controller reset.
    initial begin
        reg_i = 8'h00;
        reg_r = 8'h00;
    end
    always @(posedge clk) begin
        if (set_en) begin
            reg_i <= set_i;
            reg_r <= set_r;
        end else begin
            if (i_wr) reg_i <= i_in;
            if (r_wr) reg_r <= r_in;
        end
    end

    function automatic logic [7:0] inc_r(input logic [7:0] r);
        logic [6:0] low;
        low = r[6:0] + 7'd1;
        return {r[7], low};
    endfunction

    // One clock: scoreboard checks at the falling edge, then return 1 time
    // unit after the rising edge so the caller can drive the next cycle.
    task automatic tick();
        rfsh_exp_t e;
        logic [15:0] ea;
        @(negedge clk);
        if (m1_busy === 1'b1) begin
            tests_run++;
            if (rf_q.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_busy: m1_busy=1 at %0t but no M1 cycle expected", $time);
            end else begin
                e = rf_q.pop_front();
                if (rfsh !== e.rfsh || rfsh_addr !== e.addr) begin
                    tests_failed++;
                    $display("FAIL sb_rfsh: got rfsh=%b addr=%h, expected rfsh=%b addr=%h at %0t",
                             rfsh, rfsh_addr, e.rfsh, e.addr, $time);
                end
            end
        end
        if (im2_valid === 1'b1) begin
            tests_run++;
            if (im2_q.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_im2: im2_valid=1 at %0t but no acknowledge pending", $time);
            end else begin
                ea = im2_q.pop_front();
                if (im2_addr !== ea) begin
                    tests_failed++;
                    $display("FAIL sb_im2: got im2_addr=%h, expected %h at %0t", im2_addr, ea, $time);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic check_drained(input string name);
        tests_run++;
        if (rf_q.size() != 0 || im2_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s: %0d refresh and %0d im2 entries never observed",
                     name, rf_q.size(), im2_q.size());
        end
        rf_q.delete();
        im2_q.delete();
    endtask

    task automatic preset(input logic [7:0] i, input logic [7:0] r);
        set_en = 1'b1;
        set_i  = i;
        set_r  = r;
        tick();
        set_en = 1'b0;
    endtask

    task automatic push_m1(input logic [7:0] i, input logic [7:0] r);
        rf_q.push_back('{rfsh: 1'b0, addr: 16'h0000});
        rf_q.push_back('{rfsh: 1'b0, addr: 16'h0000});
        rf_q.push_back('{rfsh: 1'b1, addr: {i, r}});
        rf_q.push_back('{rfsh: 1'b1, addr: {i, r}});
    endtask

    // Starts from IDLE and chains n M1 cycles by raising m1_start in each T4
    // except the last.
    task automatic run_m1s(input int n);
        m1_start = 1'b1;
        tick();
        m1_start = 1'b0;
        for (int k = 0; k < n; k++) begin
            tick();
            tick();
            tick();
            if (k < n - 1) m1_start = 1'b1;
            tick();
            m1_start = 1'b0;
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        #1;
        tests_run++;
        if ({i_wr, r_wr, rfsh, im2_valid, m1_busy, m1_overrun} !== 6'b0 ||
            rfsh_addr !== 16'h0000 || im2_addr !== 16'h0000 ||
            i_in !== 8'h00 || r_in !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_outputs: got wr=%b%b rfsh=%b busy=%b im2=%b/%h rfsh_addr=%h, expected all 0",
                     i_wr, r_wr, rfsh, m1_busy, im2_valid, im2_addr, rfsh_addr);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        tests_run++;
        if (m1_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: got m1_busy=%b, expected 0", m1_busy);
        end
    endtask

    task automatic test_refresh();
        preset(8'h22, 8'h05);
        push_m1(8'h22, 8'h05);
        run_m1s(1);
        check8("refresh_r_inc", reg_r, 8'h06);
        tests_run++;
        if (m1_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL refresh_idle: got m1_busy=%b, expected 0", m1_busy);
        end
        check_drained("refresh_drain");
    endtask

    task automatic test_wrap();
        preset(8'h31, 8'hFF);
        push_m1(8'h31, 8'hFF);
        run_m1s(1);
        check8("wrap_ff", reg_r, 8'h80);
        preset(8'h31, 8'h7F);
        push_m1(8'h31, 8'h7F);
        run_m1s(1);
        check8("wrap_7f", reg_r, 8'h00);
        check_drained("wrap_drain");
    endtask

    task automatic test_back_to_back();
        logic [7:0] r;
        r = 8'h7E;
        preset(8'h0A, r);
        for (int k = 0; k < 3; k++) begin
            push_m1(8'h0A, r);
            r = inc_r(r);
        end
        run_m1s(3);
        check8("b2b_r_plus3", reg_r, 8'h01);
        tests_run++;
        if (m1_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_idle: got m1_busy=%b, expected 0", m1_busy);
        end
        check_drained("b2b_drain");
    endtask

    task automatic test_overrun();
        preset(8'h01, 8'h20);
        push_m1(8'h01, 8'h20);
        m1_start = 1'b1;
        tick();                 // IDLE -> T1
        m1_start = 1'b0;
        tick();                 // T1 -> T2
        m1_start = 1'b1;        // request lands in T2
        #1;
        tests_run++;
        if (m1_overrun !== 1'b1) begin
            tests_failed++;
            $display("FAIL overrun_pulse: got m1_overrun=%b, expected 1", m1_overrun);
        end
        tick();                 // T2 -> T3
        m1_start = 1'b0;
        #1;
        tests_run++;
        if (m1_overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL overrun_one_cycle: got m1_overrun=%b, expected 0", m1_overrun);
        end
        tick();                 // T3 -> T4
        tick();                 // T4 -> IDLE
        tick();                 // any extra M1 would show as an unexpected busy
        tick();
        check8("overrun_r_once", reg_r, 8'h21);
        check_drained("overrun_drain");
    endtask

    task automatic test_ld();
        preset(8'h09, 8'h10);
        push_m1(8'h09, 8'h10);
        m1_start = 1'b1;
        tick();
        m1_start = 1'b0;
        tick();
        tick();
        tick();                 // now in T4
        ld_r_a = 1'b1;
        a_in   = 8'h3C;
        #1;
        check8("ld_r_data", r_in, 8'h3C);
        tick();
        ld_r_a = 1'b0;
        check8("ld_r_wins", reg_r, 8'h3C);
        check_drained("ld_r_drain");

        ld_i_a = 1'b1;
        a_in   = 8'h12;
        #1;
        check8("ld_i_strobe", {7'h0, i_wr}, 8'h01);
        tick();
        ld_i_a = 1'b0;
        a_in   = 8'h00;
        #1;
        check8("ld_i_written", reg_i, 8'h12);
        check8("ld_i_idle", {7'h0, i_wr} | i_in, 8'h00);
    endtask

    task automatic test_im2();
        preset(8'h40, 8'h00);
        im2_ack = 1'b1;
        vec_in  = 8'hA7;
        im2_q.push_back(16'h40A6);
        tick();
        im2_ack = 1'b0;
        tests_run++;
        if (im2_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL im2_strobe: got im2_valid=%b, expected 1", im2_valid);
        end
        tick();
        tests_run++;
        if (im2_valid !== 1'b0 || im2_addr !== 16'h40A6) begin
            tests_failed++;
            $display("FAIL im2_hold: got valid=%b addr=%h, expected valid=0 addr=40a6", im2_valid, im2_addr);
        end

        // LD I,A in the acknowledge cycle must not change this address.
        im2_ack = 1'b1;
        vec_in  = 8'hA7;
        ld_i_a  = 1'b1;
        a_in    = 8'h55;
        im2_q.push_back(16'h40A6);
        tick();
        im2_ack = 1'b0;
        ld_i_a  = 1'b0;
        check8("im2_new_i", reg_i, 8'h55);

        // Back-to-back acknowledges.
        im2_ack = 1'b1;
        vec_in  = 8'h10;
        im2_q.push_back(16'h5510);
        tick();
        vec_in  = 8'h33;
        im2_q.push_back(16'h5532);
        tick();
        im2_ack = 1'b0;
        tick();
        check_drained("im2_drain");
    endtask

    task automatic test_reset_mid();
        preset(8'h07, 8'h20);
        push_m1(8'h07, 8'h20);
        m1_start = 1'b1;
        tick();
        m1_start = 1'b0;
        tick();
        tick();                 // now in T3
        reset = 1'b0;
        #1;
        tests_run++;
        if ({rfsh, m1_busy, r_wr, i_wr, im2_valid, m1_overrun} !== 6'b0 || rfsh_addr !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_mid_outputs: got rfsh=%b busy=%b r_wr=%b addr=%h, expected all 0",
                     rfsh, m1_busy, r_wr, rfsh_addr);
        end
        rf_q.delete();          // the aborted T3/T4 never happens
        tick();
        tick();
        reset = 1'b1;
        tick();
        check8("reset_mid_r", reg_r, 8'h20);
        tests_run++;
        if (m1_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_idle: got m1_busy=%b, expected 0", m1_busy);
        end
        push_m1(8'h07, 8'h20);
        run_m1s(1);
        check8("reset_mid_restart", reg_r, 8'h21);
        check_drained("reset_mid_drain");
    endtask

    initial begin
        reset    = 1'b0;
        m1_start = 1'b0;
        ld_i_a   = 1'b0;
        ld_r_a   = 1'b0;
        a_in     = 8'h00;
        im2_ack  = 1'b0;
        vec_in   = 8'h00;
        set_en   = 1'b0;
        set_i    = 8'h00;
        set_r    = 8'h00;

        test_reset();
        test_refresh();
        test_wrap();
        test_back_to_back();
        test_overrun();
        test_ld();
        test_im2();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_ir_refresh_ctrl
